// File: rtl/out_ctrl_pkg.sv
// Shared definitions for the output write controller: FSM state encoding and
// default widths.
package out_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FETCH   = 2'b01,
    LOAD    = 2'b10,
    PRESENT = 2'b11
  } state_t;

endpackage

// File: rtl/out_data_reg.sv
// Output word register with asynchronous active-high reset and load enable.
module out_data_reg
  import out_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/output_write_controller.sv
// Drains the output buffer one word at a time and offers each word downstream
// on a valid / r_en handshake. Optional sent-word counter: OUT_WRITE_CNT_EN.
module output_write_controller
  import out_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] buf_dout,
  output logic              buf_ren,
  input  logic              r_en,
  output logic              valid,
  output logic [DATA_W-1:0] dout
`ifdef OUT_WRITE_CNT_EN
  ,
  output logic [CNT_W-1:0]  sent_cnt
`endif
);

  state_t state, next_state;
  logic   handshake;
  logic   load;

  assign handshake = (state == PRESENT) && r_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Buffer data arrives one cycle after the pop, hence the LOAD state in between.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ctrl_en && !empty) next_state = FETCH;
      FETCH:   next_state = LOAD;
      LOAD:    next_state = PRESENT;
      PRESENT: if (handshake) next_state = (ctrl_en && !empty) ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    buf_ren = (state == FETCH);
    load    = (state == LOAD);
    valid   = (state == PRESENT);
  end

  out_data_reg #(
    .DATA_W (DATA_W)
  ) u_data_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (buf_dout),
    .q    (dout)
  );

`ifdef OUT_WRITE_CNT_EN
  // Wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sent_cnt <= '0;
    else if (handshake) sent_cnt <= sent_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_output_write_controller.sv
// Bench for output_write_controller: directed scenarios plus randomized traffic
// checked against an in-order word scoreboard and handshake-count model.
module tb_output_write_controller;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ctrl_en;
  logic              empty;
  logic [DATA_W-1:0] buf_dout;
  logic              buf_ren;
  logic              r_en;
  logic              valid;
  logic [DATA_W-1:0] dout;
`ifdef OUT_WRITE_CNT_EN
  logic [CNT_W-1:0]  sent_cnt;
`endif

  int total  = 0;
  int passed = 0;

  logic [DATA_W-1:0] bufQ[$];
  logic [DATA_W-1:0] expQ[$];
  int   sentModel = 0;
  int   renCount  = 0;
  int   cycle     = 0;
  logic prevValid = 1'b0;
  logic prevHs    = 1'b0;
  logic [DATA_W-1:0] prevDout = '0;

  output_write_controller #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl_en  (ctrl_en),
    .empty    (empty),
    .buf_dout (buf_dout),
    .buf_ren  (buf_ren),
    .r_en     (r_en),
    .valid    (valid),
    .dout     (dout)
`ifdef OUT_WRITE_CNT_EN
    ,
    .sent_cnt (sent_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Buffer behaviour: a pop presents the head word one cycle later.
  always @(posedge clk) begin
    if (buf_ren && bufQ.size() > 0) buf_dout <= bufQ.pop_front();
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] w);
    bufQ.push_back(w);
    expQ.push_back(w);
  endtask

  // Drives one cycle of inputs and scores any handshake that cycle completes.
  task automatic applyStimulus(input logic ce, input logic re, input int n = 1);
    logic hs;
    logic [DATA_W-1:0] want;
    for (int i = 0; i < n; i++) begin
      ctrl_en = ce;
      r_en    = re;
      empty   = (bufQ.size() == 0);
      hs      = valid && re;
      if (prevValid && !prevHs) begin
        checkOutput("valid_held", {31'd0, valid}, 32'd1);
        checkOutput("dout_held", {16'd0, dout}, {16'd0, prevDout});
      end
      if (hs) begin
        checkOutput("hs_expected", {31'd0, expQ.size() > 0}, 32'd1);
        want = (expQ.size() > 0) ? expQ.pop_front() : '0;
        checkOutput("hs_data", {16'd0, dout}, {16'd0, want});
        sentModel++;
      end
      prevValid = valid;
      prevHs    = hs;
      prevDout  = dout;
      @(negedge clk);
      cycle++;
      if (buf_ren) renCount++;
      if (prevHs) checkOutput("valid_drop", {31'd0, valid}, 32'd0);
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst       = 1'b0;
    expQ      = bufQ;
    sentModel = 0;
    renCount  = 0;
    prevValid = 1'b0;
    prevHs    = 1'b0;
  endtask

  initial begin
    int start;
    int rises[$];
    rst      = 1'b1;
    ctrl_en  = 1'b0;
    r_en     = 1'b0;
    empty    = 1'b1;
    buf_dout = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_ren", {31'd0, buf_ren}, 32'd0);
    checkOutput("rst_dout", {16'd0, dout}, 32'd0);
`ifdef OUT_WRITE_CNT_EN
    checkOutput("rst_cnt", {24'd0, sent_cnt}, 32'd0);
`endif
    releaseReset();

    // Reset while presenting a word discards it.
    pushWord(16'hBEEF);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("beef_valid", {31'd0, valid}, 32'd1);
    checkOutput("beef_dout", {16'd0, dout}, 32'h0000BEEF);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
    checkOutput("midrst_dout", {16'd0, dout}, 32'd0);
    checkOutput("midrst_ren", {31'd0, buf_ren}, 32'd0);
    releaseReset();
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("postrst_idle_valid", {31'd0, valid}, 32'd0);
    checkOutput("postrst_idle_ren", {31'd0, renCount}, 32'd0);

    // Single word latency.
    pushWord(16'h1234);
    applyStimulus(1'b1, 1'b1);
    checkOutput("single_c1_ren", {31'd0, buf_ren}, 32'd1);
    checkOutput("single_c1_valid", {31'd0, valid}, 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("single_c2_ren", {31'd0, buf_ren}, 32'd0);
    checkOutput("single_c2_valid", {31'd0, valid}, 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("single_c3_valid", {31'd0, valid}, 32'd1);
    checkOutput("single_c3_dout", {16'd0, dout}, 32'h00001234);
    applyStimulus(1'b1, 1'b1);
    checkOutput("single_c4_valid", {31'd0, valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("single_idle_ren", {31'd0, buf_ren}, 32'd0);
    checkOutput("single_ren_count", renCount, 32'd1);

    // Consumer stall.
    pushWord(16'hABCD);
    pushWord(16'h5555);
    applyStimulus(1'b1, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("stall_valid", {31'd0, valid}, 32'd1);
      checkOutput("stall_dout", {16'd0, dout}, 32'h0000ABCD);
      checkOutput("stall_ren", {31'd0, buf_ren}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("stall_refetch", {31'd0, buf_ren}, 32'd1);
    applyStimulus(1'b1, 1'b1, 4);
    checkOutput("stall_done_valid", {31'd0, valid}, 32'd0);

    // Four-word burst at full throughput.
    rst = 1'b1;
    releaseReset();
    for (int w = 1; w <= 4; w++) pushWord(DATA_W'(w));
    start = cycle;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (valid) rises.push_back(cycle - start);
    end
    checkOutput("burst_valid_count", rises.size(), 32'd4);
    if (rises.size() == 4) begin
      checkOutput("burst_first_latency", rises[0], 32'd3);
      for (int i = 1; i < 4; i++) checkOutput("burst_gap", rises[i] - rises[i-1], 32'd3);
    end
    checkOutput("burst_ren_count", renCount, 32'd4);
    checkOutput("burst_end_valid", {31'd0, valid}, 32'd0);
`ifdef OUT_WRITE_CNT_EN
    checkOutput("burst_cnt", {24'd0, sent_cnt}, 32'd4);
`endif

    // ctrl_en dropped while presenting.
    pushWord(16'h0A0A);
    pushWord(16'h0B0B);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("drop_present", {31'd0, valid}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("drop_still_valid", {31'd0, valid}, 32'd1);
    start = renCount;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("drop_idle_valid", {31'd0, valid}, 32'd0);
      checkOutput("drop_idle_ren", {31'd0, buf_ren}, 32'd0);
    end
    checkOutput("drop_no_fetch", renCount - start, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && bufQ.size() < 8) pushWord(DATA_W'($urandom));
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 200 && (expQ.size() > 0 || valid); i++) applyStimulus(1'b1, 1'b1);
    checkOutput("rand_drained", expQ.size(), 32'd0);
`ifdef OUT_WRITE_CNT_EN
    checkOutput("rand_cnt", {24'd0, sent_cnt}, sentModel % (1 << CNT_W));
`endif

    // Counter wrap: 257 handshakes from reset.
    rst = 1'b1;
    releaseReset();
    for (int w = 0; w < 257; w++) pushWord(DATA_W'(w * 3 + 7));
    for (int i = 0; i < 1000 && (expQ.size() > 0 || valid); i++) applyStimulus(1'b1, 1'b1);
    checkOutput("wrap_drained", expQ.size(), 32'd0);
    checkOutput("wrap_hs_count", sentModel, 32'd257);
`ifdef OUT_WRITE_CNT_EN
    checkOutput("wrap_cnt", {24'd0, sent_cnt}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
